mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the pipelined core's instruction-fetch port and data (MEM-stage) port. Sequences each access over a fixed number of wait states and generates the stall enables for the PC and the pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). Sits between the PC/IF stage, the MEM stage and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the arbiter, the core's IF and MEM stages and the memory macro.
// Latency: none; this interface carries signals only.
// Backpressure: the requester holds req/addr/wdata until ready; the stall lines freeze the pipeline meanwhile.
//   slave  : arbiter view (requests and ram_rdata in; ready/rdata/ram_*/stall out)
//   master : core + memory view (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  // data (MEM-stage) port
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  // memory macro
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  // pipeline hold enables
  logic                  stall_front;
  logic                  stall_back;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall_front, stall_back
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, stall_front, stall_back
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage, and drives the pipeline stall enables.
// Latency: a request seen while idle completes WAIT_STATES cycles later; a queued fetch completes within 2*WAIT_STATES.
// Backpressure: requesters hold their request until ready; stall_front/stall_back freeze the pipeline meanwhile.
//   Ports: clk, reset (async, active low), bus (mem_port_arbiter_if.slave).
//   Optional macro MEM_PORT_ARBITER_PERF_EN adds saturating counters perf_if_grants,
//   perf_mem_grants and perf_stall_cycles, each PERF_WIDTH bits wide.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1    // 1..15
`ifdef MEM_PORT_ARBITER_PERF_EN
  , parameter int PERF_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
`ifdef MEM_PORT_ARBITER_PERF_EN
  , output logic [PERF_WIDTH-1:0] perf_if_grants
  , output logic [PERF_WIDTH-1:0] perf_mem_grants
  , output logic [PERF_WIDTH-1:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Write/read decision is captured on grant so a request dropped mid-access still commits.
  logic       we_q, we_d;

  logic                  mem_req;
  logic                  done;
  logic                  if_ready_c;
  logic                  mem_ready_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;
  logic                  stall_back_c;
  logic                  stall_front_c;

  assign mem_req = bus.mem_rd | bus.mem_wr;
  assign done    = (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    ram_addr_c    = '0;
    ram_wdata_c   = '0;
    if_ready_c    = 1'b0;
    mem_ready_c   = 1'b0;
    bus.if_rdata  = '0;
    bus.mem_rdata = '0;

    case (state_q)
      IDLE: begin
        // Data port wins: it carries the older instruction.
        if (mem_req) begin
          state_d = GRANT_MEM;
          cnt_d   = WS;
          we_d    = bus.mem_wr;
        end else if (bus.if_req) begin
          state_d = GRANT_IF;
          cnt_d   = WS;
          we_d    = 1'b0;
        end
      end

      GRANT_IF: begin
        bus.ram_en  = 1'b1;
        ram_addr_c  = bus.if_addr;
        ram_wdata_c = bus.mem_wdata;
        cnt_d       = cnt_q - 4'd1;
        if (done) begin
          if_ready_c   = 1'b1;
          bus.if_rdata = bus.ram_rdata;
          // Hand over straight to a waiting data access; never re-grant the completing port.
          if (mem_req) begin
            state_d = GRANT_MEM;
            cnt_d   = WS;
            we_d    = bus.mem_wr;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GRANT_MEM: begin
        bus.ram_en  = 1'b1;
        bus.ram_we  = we_q;
        ram_addr_c  = bus.mem_addr;
        ram_wdata_c = bus.mem_wdata;
        cnt_d       = cnt_q - 4'd1;
        if (done) begin
          mem_ready_c   = 1'b1;
          bus.mem_rdata = bus.ram_rdata;
          if (bus.if_req) begin
            state_d = GRANT_IF;
            cnt_d   = WS;
            we_d    = 1'b0;
          end else begin
            state_d = IDLE;
            we_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        we_d    = 1'b0;
      end
    endcase
  end

  assign stall_back_c  = mem_req & ~mem_ready_c;
  assign stall_front_c = stall_back_c | (bus.if_req & ~if_ready_c);

  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_wdata   = ram_wdata_c;
  assign bus.if_ready    = if_ready_c;
  assign bus.mem_ready   = mem_ready_c;
  assign bus.stall_back  = stall_back_c;
  assign bus.stall_front = stall_front_c;

`ifdef MEM_PORT_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_grants    <= '0;
      perf_mem_grants   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_ready_c && (perf_if_grants != '1))
        perf_if_grants <= perf_if_grants + PERF_WIDTH'(1);
      if (mem_ready_c && (perf_mem_grants != '1))
        perf_mem_grants <= perf_mem_grants + PERF_WIDTH'(1);
      if (stall_front_c && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT_STATES 1, 2, 3) share one stimulus, sel picks the observed one.
// Expected completions (cycle, data) are queued at stimulus time and popped when a ready pulse is seen.
// Per-cycle control outputs are compared inline in each scenario task.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  int   sel = 0;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;

  logic          if_ready_a[3];
  logic [DW-1:0] if_rdata_a[3];
  logic          mem_ready_a[3];
  logic [DW-1:0] mem_rdata_a[3];
  logic          ram_en_a[3];
  logic          ram_we_a[3];
  logic [AW-1:0] ram_addr_a[3];
  logic [DW-1:0] ram_wdata_a[3];
  logic          stall_front_a[3];
  logic          stall_back_a[3];
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0]   perf_if_a[3];
  logic [31:0]   perf_mem_a[3];
  logic [31:0]   perf_stall_a[3];
`endif

  exp_t if_q[$];
  exp_t mem_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: one fixed instruction word, everything else derived from the address.
  function automatic logic [31:0] ram_model(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.if_req    = if_req;
    assign bus.if_addr   = if_addr;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.ram_rdata = ram_model(bus.ram_addr);

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(g + 1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MEM_PORT_ARBITER_PERF_EN
      , .perf_if_grants    (perf_if_a[g])
      , .perf_mem_grants   (perf_mem_a[g])
      , .perf_stall_cycles (perf_stall_a[g])
`endif
    );

    assign if_ready_a[g]    = bus.if_ready;
    assign if_rdata_a[g]    = bus.if_rdata;
    assign mem_ready_a[g]   = bus.mem_ready;
    assign mem_rdata_a[g]   = bus.mem_rdata;
    assign ram_en_a[g]      = bus.ram_en;
    assign ram_we_a[g]      = bus.ram_we;
    assign ram_addr_a[g]    = bus.ram_addr;
    assign ram_wdata_a[g]   = bus.ram_wdata;
    assign stall_front_a[g] = bus.stall_front;
    assign stall_back_a[g]  = bus.stall_back;
  end

  // Scoreboard: every ready pulse on the observed instance must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (if_ready_a[sel]) begin
      checks++;
      if (if_q.size() == 0) begin
        failures++; $display("FAIL if_unexpected_ready cyc=%0d got=1 exp=0", cyc);
      end else begin
        e = if_q.pop_front();
        if (cyc !== e.cyc || if_rdata_a[sel] !== e.data) begin
          failures++;
          $display("FAIL if_completion got cyc=%0d data=%h exp cyc=%0d data=%h", cyc, if_rdata_a[sel], e.cyc, e.data);
        end
      end
    end
    if (mem_ready_a[sel]) begin
      checks++;
      if (mem_q.size() == 0) begin
        failures++; $display("FAIL mem_unexpected_ready cyc=%0d got=1 exp=0", cyc);
      end else begin
        e = mem_q.pop_front();
        if (cyc !== e.cyc || mem_rdata_a[sel] !== e.data) begin
          failures++;
          $display("FAIL mem_completion got cyc=%0d data=%h exp cyc=%0d data=%h", cyc, mem_rdata_a[sel], e.cyc, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if_q.delete(); mem_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int r;
    sel = 0; reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++; if (ram_en_a[s] !== 1'b0) begin failures++; $display("FAIL rst_ram_en inst=%0d got=%b exp=0", s, ram_en_a[s]); end
      checks++; if (ram_addr_a[s] !== '0 || ram_we_a[s] !== 1'b0) begin failures++; $display("FAIL rst_ram_addr_we inst=%0d got=%h/%b exp=0/0", s, ram_addr_a[s], ram_we_a[s]); end
      checks++; if (if_ready_a[s] !== 1'b0 || if_rdata_a[s] !== '0) begin failures++; $display("FAIL rst_if_out inst=%0d got=%b/%h exp=0/0", s, if_ready_a[s], if_rdata_a[s]); end
      checks++; if (stall_front_a[s] !== 1'b1 || stall_back_a[s] !== 1'b0) begin failures++; $display("FAIL rst_stalls inst=%0d got=%b/%b exp=1/0", s, stall_front_a[s], stall_back_a[s]); end
    end
    @(posedge clk); #1 reset = 1'b1; r = cyc;
    e.cyc = r + 1; e.data = ram_model(32'h0000_0100); if_q.push_back(e);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++; if (ram_en_a[s] !== 1'b0 || if_ready_a[s] !== 1'b0) begin failures++; $display("FAIL rst_first_cycle inst=%0d got=%b/%b exp=0/0", s, ram_en_a[s], if_ready_a[s]); end
    end
    @(posedge clk); #1;
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_q.size() != 0) begin failures++; $display("FAIL rst_pending got=%0d exp=0", if_q.size()); end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    int r;
    sel = 2; do_reset();
    @(posedge clk); #1 mem_rd = 1'b1; mem_addr = 32'h1001_0008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ram_en_a[2] !== 1'b1) begin failures++; $display("FAIL abort_pre_en got=%b exp=1", ram_en_a[2]); end
    reset = 1'b0;
    #1;
    checks++; if (ram_en_a[2] !== 1'b0 || mem_ready_a[2] !== 1'b0) begin failures++; $display("FAIL abort_async got=%b/%b exp=0/0", ram_en_a[2], mem_ready_a[2]); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; r = cyc;
    e.cyc = r + 3; e.data = ram_model(32'h1001_0008); mem_q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ram_en_a[2] !== (k >= 1 && k <= 3)) begin failures++; $display("FAIL abort_ram_en k=%0d got=%b exp=%b", k, ram_en_a[2], (k >= 1 && k <= 3)); end
      checks++; if (mem_ready_a[2] !== (k == 3)) begin failures++; $display("FAIL abort_ready k=%0d got=%b exp=%b", k, mem_ready_a[2], (k == 3)); end
      @(posedge clk); #1;
      if (k == 3) mem_rd = 1'b0;
    end
    checks++; if (mem_q.size() != 0) begin failures++; $display("FAIL abort_pending got=%0d exp=0", mem_q.size()); end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    sel = 0; do_reset();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h0040_0000;
    e.cyc = cyc + 1; e.data = 32'h2008_0005; if_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ram_en_a[0] !== (k == 1) || if_ready_a[0] !== (k == 1)) begin failures++; $display("FAIL fetch_en_ready k=%0d got=%b/%b exp=%b", k, ram_en_a[0], if_ready_a[0], (k == 1)); end
      checks++; if (stall_front_a[0] !== (k == 0)) begin failures++; $display("FAIL fetch_stall_front k=%0d got=%b exp=%b", k, stall_front_a[0], (k == 0)); end
      if (k == 1) begin
        checks++; if (ram_addr_a[0] !== 32'h0040_0000 || if_rdata_a[0] !== 32'h2008_0005) begin failures++; $display("FAIL fetch_addr_data got=%h/%h exp=00400000/20080005", ram_addr_a[0], if_rdata_a[0]); end
      end
      @(posedge clk); #1;
      if (k == 1) if_req = 1'b0;
    end
    checks++; if (if_q.size() != 0) begin failures++; $display("FAIL fetch_pending got=%0d exp=0", if_q.size()); end
  endtask

  task automatic test_contention();
    exp_t e;
    int t0;
    logic exp_we;
    logic [31:0] exp_addr;
    sel = 1; do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0040_0010;
    mem_wr = 1'b1; mem_addr = 32'h1001_0000; mem_wdata = 32'hDEAD_BEEF;
    t0 = cyc;
    e.cyc = t0 + 2; e.data = ram_model(32'h1001_0000); mem_q.push_back(e);
    e.cyc = t0 + 4; e.data = ram_model(32'h0040_0010); if_q.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_we   = (k == 1 || k == 2);
      exp_addr = exp_we ? 32'h1001_0000 : ((k == 3 || k == 4) ? 32'h0040_0010 : 32'h0);
      checks++; if (ram_en_a[1] !== (k >= 1 && k <= 4)) begin failures++; $display("FAIL cont_ram_en k=%0d got=%b exp=%b", k, ram_en_a[1], (k >= 1 && k <= 4)); end
      checks++; if (ram_we_a[1] !== exp_we) begin failures++; $display("FAIL cont_ram_we k=%0d got=%b exp=%b", k, ram_we_a[1], exp_we); end
      checks++; if (ram_addr_a[1] !== exp_addr) begin failures++; $display("FAIL cont_ram_addr k=%0d got=%h exp=%h", k, ram_addr_a[1], exp_addr); end
      if (exp_we) begin
        checks++; if (ram_wdata_a[1] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cont_ram_wdata k=%0d got=%h exp=deadbeef", k, ram_wdata_a[1]); end
      end
      checks++; if (stall_back_a[1] !== (k <= 1)) begin failures++; $display("FAIL cont_stall_back k=%0d got=%b exp=%b", k, stall_back_a[1], (k <= 1)); end
      checks++; if (stall_front_a[1] !== (k <= 3)) begin failures++; $display("FAIL cont_stall_front k=%0d got=%b exp=%b", k, stall_front_a[1], (k <= 3)); end
      @(posedge clk); #1;
      if (k == 2) mem_wr = 1'b0;
      if (k == 4) if_req = 1'b0;
    end
    checks++; if (if_q.size() != 0 || mem_q.size() != 0) begin failures++; $display("FAIL cont_pending got=%0d/%0d exp=0/0", if_q.size(), mem_q.size()); end
`ifdef MEM_PORT_ARBITER_PERF_EN
    checks++; if (perf_if_a[1] !== 32'd1) begin failures++; $display("FAIL perf_if_grants got=%0d exp=1", perf_if_a[1]); end
    checks++; if (perf_mem_a[1] !== 32'd1) begin failures++; $display("FAIL perf_mem_grants got=%0d exp=1", perf_mem_a[1]); end
    checks++; if (perf_stall_a[1] !== 32'd4) begin failures++; $display("FAIL perf_stall_cycles got=%0d exp=4", perf_stall_a[1]); end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t0;
    logic odd;
    sel = 0; do_reset();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h0040_0000; t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      e.cyc = t0 + 1 + 2 * i; e.data = ram_model(32'h0040_0000 + 32'(4 * i)); if_q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      odd = (k % 2 == 1);
      checks++; if (if_ready_a[0] !== odd || ram_en_a[0] !== odd) begin failures++; $display("FAIL stream_ready_en k=%0d got=%b/%b exp=%b", k, if_ready_a[0], ram_en_a[0], odd); end
      checks++; if (stall_front_a[0] !== !odd) begin failures++; $display("FAIL stream_stall_front k=%0d got=%b exp=%b", k, stall_front_a[0], !odd); end
      if (odd) begin
        checks++; if (ram_addr_a[0] !== 32'h0040_0000 + 32'(4 * (k / 2))) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, ram_addr_a[0], 32'h0040_0000 + 32'(4 * (k / 2))); end
      end
      @(posedge clk); #1;
      if (odd) begin
        if (k == 7) if_req = 1'b0;
        else if_addr = if_addr + 32'd4;
      end
    end
    checks++; if (if_q.size() != 0) begin failures++; $display("FAIL stream_pending got=%0d exp=0", if_q.size()); end
  endtask

  task automatic test_wait_read();
    exp_t e;
    sel = 2; do_reset();
    @(posedge clk); #1 mem_rd = 1'b1; mem_addr = 32'h1001_0004;
    e.cyc = cyc + 3; e.data = ram_model(32'h1001_0004); mem_q.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (ram_en_a[2] !== (k >= 1 && k <= 3) || ram_we_a[2] !== 1'b0) begin failures++; $display("FAIL wread_en_we k=%0d got=%b/%b exp=%b/0", k, ram_en_a[2], ram_we_a[2], (k >= 1 && k <= 3)); end
      checks++; if (mem_ready_a[2] !== (k == 3)) begin failures++; $display("FAIL wread_ready k=%0d got=%b exp=%b", k, mem_ready_a[2], (k == 3)); end
      checks++; if (mem_rdata_a[2] !== ((k == 3) ? ram_model(32'h1001_0004) : 32'h0)) begin failures++; $display("FAIL wread_rdata k=%0d got=%h exp=%h", k, mem_rdata_a[2], ((k == 3) ? ram_model(32'h1001_0004) : 32'h0)); end
      checks++; if (stall_back_a[2] !== (k <= 2)) begin failures++; $display("FAIL wread_stall_back k=%0d got=%b exp=%b", k, stall_back_a[2], (k <= 2)); end
      @(posedge clk); #1;
      if (k == 3) mem_rd = 1'b0;
    end
    checks++; if (mem_q.size() != 0) begin failures++; $display("FAIL wread_pending got=%0d exp=0", mem_q.size()); end
  endtask

  // rd+wr together is a write; dropping the request mid-grant still commits it,
  // and a fetch raised meanwhile is granted on the write's completion edge.
  task automatic test_dropped_write();
    exp_t e;
    int t0;
    sel = 2; do_reset();
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h1001_0020; mem_wdata = 32'h1234_5678; t0 = cyc;
    e.cyc = t0 + 3; e.data = ram_model(32'h1001_0020); mem_q.push_back(e);
    e.cyc = t0 + 6; e.data = ram_model(32'h0040_0040); if_q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (ram_we_a[2] !== (k >= 1 && k <= 3)) begin failures++; $display("FAIL drop_ram_we k=%0d got=%b exp=%b", k, ram_we_a[2], (k >= 1 && k <= 3)); end
      checks++; if (ram_en_a[2] !== (k >= 1 && k <= 6)) begin failures++; $display("FAIL drop_ram_en k=%0d got=%b exp=%b", k, ram_en_a[2], (k >= 1 && k <= 6)); end
      checks++; if (stall_back_a[2] !== (k == 0)) begin failures++; $display("FAIL drop_stall_back k=%0d got=%b exp=%b", k, stall_back_a[2], (k == 0)); end
      if (k >= 4 && k <= 6) begin
        checks++; if (ram_addr_a[2] !== 32'h0040_0040) begin failures++; $display("FAIL drop_if_addr k=%0d got=%h exp=00400040", k, ram_addr_a[2]); end
      end
      @(posedge clk); #1;
      if (k == 0) begin mem_rd = 1'b0; mem_wr = 1'b0; end
      if (k == 1) begin if_req = 1'b1; if_addr = 32'h0040_0040; end
      if (k == 6) if_req = 1'b0;
    end
    checks++; if (if_q.size() != 0 || mem_q.size() != 0) begin failures++; $display("FAIL drop_pending got=%0d/%0d exp=0/0", if_q.size(), mem_q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_single_fetch();
    test_contention();
    test_back_to_back();
    test_wait_read();
    test_dropped_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
